rr_prio_arbiter: RTL and testbench
==================================

Name: rr_prio_arbiter

Overview:
- 8-requester arbiter that shares one resource (bus/datapath slot) among request lines.
- Two modes:
  - Fixed priority: the highest index wins, bit 7 highest, matching the team's priority-encoder ordering.
  - Round-robin: rotating priority.
- The owner holds the grant until it signals done, drops its request, or exceeds a hold limit.
- Sits between the request sources and the shared resource's select mux.

Parameters:
- N_REQ, 8, number of requesters. Fixed at 8; the parameter exists for the package constant only.
- HOLD_MAX, 16, maximum consecutive cycles one owner may hold the grant. Must be ≥ 2.
- CNT_W, $clog2(HOLD_MAX), width of the hold counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  request lines, level; bit i = requester i.
- done  in  1  current owner finished. Ignored when grant_valid=0.
- mode  in  1  0 = fixed priority, 1 = round-robin. Sampled only at arbitration.
- grant  out  8  one-hot grant, registered.
- grant_idx  out  3  binary index of the owner, registered.
- grant_valid  out  1  a grant is active, registered.
- timeout  out  1  one-cycle pulse: owner was forcibly released.

Behaviour:
- Reset (async, immediate, no clock needed):
  - Outputs: grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - Internal: state=IDLE, hold_cnt=0, rr_last=7.
- FSM states: IDLE, BUSY. Next-state and output registers update on rising clk only.
- IDLE:
  - req=0: stay IDLE, outputs 0.
  - req≠0: winner chosen combinationally. On the next edge, load grant/grant_idx/grant_valid=1, set hold_cnt=0, go BUSY.
  - Latency from req assertion (sampled at an edge) to grant visible: 1 cycle.
- Winner selection:
  - mode=0: highest set bit of req.
  - mode=1: first set bit scanning upward from rr_last+1, wrapping 7→0. rr_last itself is checked last.
- BUSY:
  - Release conditions, checked each edge, in priority order:
    1. done=1.
    2. req[grant_idx]=0.
    3. hold_cnt==HOLD_MAX-1.
  - On release: go IDLE, grant/grant_valid/grant_idx cleared (grant_idx→0), rr_last←grant_idx.
  - timeout=1 for exactly the cycle after release, and only if condition 3 alone caused it.
  - done or req-drop coinciding with the hold limit: normal release, timeout=0.
  - No release: hold_cnt increments; it saturates by construction.
  - grant_valid is high at most HOLD_MAX consecutive cycles.
- Turnaround: at least one cycle of grant_valid=0 between consecutive grants, including re-grant to the same requester.
- Requests from other lines during BUSY are ignored; there is no preemption.
- mode changes during BUSY take effect at the next arbitration.
- rr_last updates in both modes, so switching to round-robin continues from the last owner.
- Fixed mode after timeout: the same requester may win again. Starvation of low indices is accepted in mode 0.
- Invariants:
  - grant is always one-hot or zero.
  - grant==(1<<grant_idx) when grant_valid=1.
  - grant==0 when grant_valid=0.
- Reset asserted mid-BUSY: grant drops asynchronously; no timeout pulse.

Decomposition:
- Package arb_pkg: N_REQ=8, IDX_W=3, typedef enum state_t {IDLE, BUSY}, typedef logic [N_REQ-1:0] req_vec_t.
- Sub-module prio_pick8 (combinational):
  - Inputs: req_vec_t req, 3-bit base, mode.
  - Outputs: 3-bit idx, found.
  - Implements both selection rules, with rotate → priority-pick → un-rotate for round-robin.
- The top module holds the FSM, hold counter, rr_last and output registers.

Test Plan:
- Reset, then req=8'h00 for 5 cycles → grant=0, grant_idx=0, grant_valid=0, timeout=0 throughout. Assert rst mid-clock → outputs 0 without an edge.
- mode=0, req=8'b0010_0101 → 1 cycle later grant=8'h20, idx=5. Pulse done with req→8'b0000_0101 → grant_valid=0 for 1 cycle, then grant=8'h04, idx=2.
- mode=1, req=8'hFF held, done pulsed the cycle after each grant → idx sequence 0,1,2,3,4,5,6,7,0, each separated by exactly one grant_valid=0 cycle.
- HOLD_MAX=16, req=8'h08 held, done=0 → grant_valid high exactly 16 cycles. timeout=1 on the first low cycle. Re-grant idx=3 one cycle later.
- Owner idx=4 drops req[4] at hold_cnt=6 → release next edge, timeout=0. Separately, done coincides with hold_cnt=15 → timeout=0.
- mode=1, owner idx=6 in BUSY, assert rst → grant=0 immediately. Release rst with req=8'h41 → first grant idx=0 (rr_last reset to 7).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and types for the 8-way grant arbiter.
// Pure declarations: no logic, no latency, no flow control.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef logic [N_REQ-1:0] req_vec_t;

endpackage

// File: rtl/prio_pick8.sv
// Winner selection over 8 request lines: highest index (mode 0) or round-robin after base (mode 1).
// Latency: combinational. No backpressure; found=0 when no line is requesting.
module prio_pick8
    import arb_pkg::*;
(
    input  req_vec_t         req,
    input  logic [IDX_W-1:0] base,
    input  logic             mode,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] start;
    req_vec_t         rot;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Rotation puts line base+1 at position 0, so the lowest set bit of rot is the
    // round-robin winner and base itself is reached last; index arithmetic wraps at 8.
    assign start = base + IDX_W'(1);

    always_comb begin
        rot    = '0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[start + IDX_W'(i)];
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i]) hi_idx = IDX_W'(i);
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) lo_idx = IDX_W'(i);
        end
    end

    assign found = |req;
    assign idx   = mode ? (start + lo_idx) : hi_idx;

endmodule

// File: rtl/rr_prio_arbiter.sv
// 8-requester grant arbiter with fixed/round-robin selection, hold limit and forced-release pulse.
// Latency: 1 cycle request-to-grant; owner holds until done, request drop or HOLD_MAX cycles; no preemption.
module rr_prio_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = $clog2(HOLD_MAX)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    input  logic       mode,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0] rr_last_q, rr_last_d;
    req_vec_t         grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic             grant_valid_q, grant_valid_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             rel_done;
    logic             rel_drop;
    logic             rel_lim;

    prio_pick8 u_pick (
        .req   (req),
        .base  (rr_last_q),
        .mode  (mode),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign rel_done = done;
    assign rel_drop = ~req[grant_idx_q];
    assign rel_lim  = (hold_cnt_q == CNT_W'(HOLD_MAX - 1));

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        rr_last_d     = rr_last_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d       = BUSY;
                    grant_d       = req_vec_t'(1) << pick_idx;
                    grant_idx_d   = pick_idx;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = '0;
                end else begin
                    grant_d       = '0;
                    grant_idx_d   = '0;
                    grant_valid_d = 1'b0;
                end
            end
            BUSY: begin
                if (rel_done || rel_drop || rel_lim) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    grant_idx_d   = '0;
                    grant_valid_d = 1'b0;
                    rr_last_d     = grant_idx_q;
                    // Only a pure hold-limit release counts as forced.
                    timeout_d     = rel_lim && !rel_done && !rel_drop;
                end else begin
                    hold_cnt_d    = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            rr_last_q     <= IDX_W'(N_REQ - 1);
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            rr_last_q     <= rr_last_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// Bench for rr_prio_arbiter: directed vector table, corner-case sequences, then random traffic vs a reference model.
module tb_rr_prio_arbiter;

    localparam int HOLD_MAX = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       mode;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: owner index (-1 = none), cycles held so far, last owner.
    int m_owner;
    int m_held;
    int m_last;
    bit m_to;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic       mode;
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic       to;
    } vec_t;

    vec_t tbl[20];

    rr_prio_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .mode        (mode),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] i,
                           input logic v, input logic t);
        chk({tag, ".grant"},       32'(grant),       32'(g));
        chk({tag, ".grant_idx"},   32'(grant_idx),   32'(i));
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(v));
        chk({tag, ".timeout"},     32'(timeout),     32'(t));
    endtask

    task automatic m_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 7;
        m_to    = 0;
    endtask

    // One clock edge of the arbitration rules, applied to the inputs currently driven.
    task automatic m_step();
        int w;
        if (m_owner < 0) begin
            m_to = 0;
            if (req != 8'h00) begin
                w = -1;
                if (mode) begin
                    for (int k = 1; k <= 8; k++)
                        if (w < 0 && req[(m_last + k) % 8]) w = (m_last + k) % 8;
                end else begin
                    for (int c = 7; c >= 0; c--)
                        if (w < 0 && req[c]) w = c;
                end
                m_owner = w;
                m_held  = 1;
            end
        end else if (done || !req[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
            m_to    = 0;
        end else if (m_held >= HOLD_MAX) begin
            m_last  = m_owner;
            m_owner = -1;
            m_to    = 1;
        end else begin
            m_held++;
            m_to = 0;
        end
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic [7:0] eg;
        logic [2:0] ei;
        eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        ei = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        chk_out(tag, eg, ei, m_owner >= 0, m_to);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        mode = 1'b0;
        m_reset();
        #3;
        chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //                req    done  mode  grant  idx   v     to
        tbl[0]  = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[5]  = '{8'h25, 1'b0, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
        tbl[6]  = '{8'h05, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{8'h05, 1'b0, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[8]  = '{8'h05, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[9]  = '{8'h00, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[10] = '{8'h0C, 1'b0, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[11] = '{8'h0C, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[12] = '{8'h0C, 1'b0, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[13] = '{8'h00, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[14] = '{8'h81, 1'b0, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[15] = '{8'h81, 1'b0, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[16] = '{8'h81, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[17] = '{8'h81, 1'b0, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[18] = '{8'h81, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[19] = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            mode = tbl[i].mode;
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].idx, tbl[i].v, tbl[i].to);
        end
        done = 1'b0;

        // Round-robin sweep from reset: 0..7 then wrap to 0, one idle cycle between grants.
        apply_reset();
        mode = 1'b1;
        req  = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            tick();
            chk_out($sformatf("rr_grant%0d", g), 8'(1 << (g % 8)), 3'(g % 8), 1'b1, 1'b0);
            done = 1'b1;
            tick();
            chk_out($sformatf("rr_gap%0d", g), 8'h00, 3'd0, 1'b0, 1'b0);
            done = 1'b0;
        end

        // Hold limit: single requester never finishes.
        req  = 8'h00;
        mode = 1'b0;
        tick();
        req = 8'h08;
        tick();
        cnt = 0;
        while (grant_valid === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("hold_len", 32'(cnt), 32'(HOLD_MAX));
        chk_out("hold_release", 8'h00, 3'd0, 1'b0, 1'b1);
        tick();
        chk_out("hold_regrant", 8'h08, 3'd3, 1'b1, 1'b0);

        // Request drop while held, then done landing on the last allowed cycle.
        req = 8'h00;
        tick();
        req = 8'h10;
        tick();
        for (int k = 0; k < 6; k++) tick();
        chk_out("drop_held", 8'h10, 3'd4, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        chk_out("drop_release", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'h10;
        tick();
        for (int k = 0; k < HOLD_MAX - 1; k++) tick();
        chk_out("done_at_limit_held", 8'h10, 3'd4, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk_out("done_at_limit", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;
        req  = 8'h00;
        tick();

        // Asynchronous reset while an owner is active, then round-robin restarts after 7.
        apply_reset();
        mode = 1'b1;
        req  = 8'h40;
        tick();
        chk_out("pre_arst", 8'h40, 3'd6, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        chk_out("mid_arst", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'h41;
        #1;
        rst = 1'b0;
        tick();
        chk_out("post_arst", 8'h01, 3'd0, 1'b1, 1'b0);

        // Random traffic against the reference model.
        apply_reset();
        req  = 8'h00;
        done = 1'b0;
        mode = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) begin
                if ($urandom_range(1) == 0) req = 8'($urandom);
                else                        req = 8'(1 << $urandom_range(7)) | 8'(1 << $urandom_range(7));
            end
            done = ($urandom_range(9) == 0);
            if ($urandom_range(15) == 0) mode = ~mode;
            tick();
            chk_model($sformatf("rand%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
